// File: rtl/pwm_pkg.sv
// pwm_pkg: constants and types shared by the PWM channel and its users.
//
// Contents:
//   PWM_PERIOD   - default samples per PWM period. This is also the
//                  full-scale brightness value.
//   PWM_DUTY_W   - default width of a duty / brightness value.
//   duty_t       - the duty type, logic [PWM_DUTY_W-1:0].
//   FULL_SCALE   - PWM_PERIOD expressed as a duty_t.
//   cnt_width()  - width of a sample counter that covers 0..period-1.
package pwm_pkg;

    localparam int PWM_PERIOD = 200;
    localparam int PWM_DUTY_W = 8;

    typedef logic [PWM_DUTY_W-1:0] duty_t;

    localparam duty_t FULL_SCALE = duty_t'(PWM_PERIOD);

    // ceil(log2(period)), but never less than one bit. A period of 2
    // still needs a 1-bit counter.
    function automatic int cnt_width(input int period);
        int w;
        w = $clog2(period);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/pwm_if.sv
// pwm_if: signal bundle between a PWM channel and its controller.
//
// Parameters:
//   DUTY_W - width of on_time.
//   CNT_W  - width of the sample counter. It is exported so that a user can
//            line up with the period start.
// Signals:
//   on_time - requested high time, in samples per period (controller -> pwm).
//   out     - registered PWM waveform (pwm -> controller).
//   cnt     - current sample index, 0..PERIOD-1 (pwm -> controller).
// Modports:
//   master - controller side: drives on_time, observes out and cnt.
//   slave  - PWM channel side.
interface pwm_if #(
    parameter int DUTY_W = 8,
    parameter int CNT_W  = 8
);
    logic [DUTY_W-1:0] on_time;
    logic              out;
    logic [CNT_W-1:0]  cnt;

    modport master (output on_time, input out, input cnt);
    modport slave  (input on_time, output out, output cnt);
endinterface

// File: rtl/pwm.sv
// pwm: single-channel pulse-width modulator.
//
// The output is high for on_time samples out of every PERIOD samples.
// on_time is captured only when a new period starts, so changing it in the
// middle of a period cannot produce a runt pulse or a glitch.
//
// Parameters:
//   PERIOD - samples per period. Legal range is 2..256. This value is also
//            full scale: any duty of PERIOD or more holds the output high.
//   DUTY_W - width of on_time.
// Ports:
//   clk - PWM sample clock. All logic uses its rising edge.
//   rst - synchronous, active-high reset. It clears cnt, duty and out.
//   bus - pwm_if.slave port: on_time in; out and cnt back.
module pwm
    import pwm_pkg::*;
#(
    parameter int PERIOD = PWM_PERIOD,
    parameter int DUTY_W = PWM_DUTY_W
) (
    input  logic  clk,
    input  logic  rst,
    pwm_if.slave  bus
);

    localparam int CNT_W = cnt_width(PERIOD);
    // The compare runs at the wider of the two operand widths. This keeps a
    // large duty from being truncated, so duty >= PERIOD saturates high
    // instead of wrapping.
    localparam int CMP_W = (CNT_W > DUTY_W) ? CNT_W : DUTY_W;

    typedef logic [CNT_W-1:0]  cnt_t;
    typedef logic [DUTY_W-1:0] dut_t;
    typedef logic [CMP_W-1:0]  cmp_t;

    localparam cnt_t CNT_LAST = cnt_t'(PERIOD - 1);

    cnt_t cnt_reg;
    cnt_t cnt_next;
    dut_t duty_reg;
    dut_t duty_next;
    logic out_reg;
    logic out_next;
    logic wrap;

    always_comb begin
        wrap      = (cnt_reg == CNT_LAST);
        cnt_next  = wrap ? '0 : cnt_reg + cnt_t'(1);
        // The new duty is taken on the wrap edge. An on_time that changes
        // in that same cycle is therefore used for the period that starts.
        duty_next = wrap ? bus.on_time : duty_reg;
        // out is computed from the next-state values. This way out, cnt and
        // duty all change on the same edge, and the first high sample of a
        // period lines up with cnt == 0.
        out_next  = (cmp_t'(cnt_next) < cmp_t'(duty_next));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg  <= '0;
            duty_reg <= '0;
            out_reg  <= 1'b0;
        end else begin
            cnt_reg  <= cnt_next;
            duty_reg <= duty_next;
            out_reg  <= out_next;
        end
    end

    assign bus.out = out_reg;
    assign bus.cnt = cnt_reg;

endmodule

// File: tb/tb_pwm.sv
// tb_pwm: scoreboard bench for the pwm block at its default parameters.
// The stimulus process drives rst and on_time once per cycle, on the falling
// edge. For each cycle it pushes the expected cnt and out, as they should
// read after the next rising edge. A separate monitor pops one entry 1 ns
// after every rising edge and compares it with the DUT.
module tb_pwm;
    import pwm_pkg::*;

    localparam int P = PWM_PERIOD;

    typedef struct {
        logic out;
        int   cnt;
    } exp_t;

    logic clk;
    logic rst;
    exp_t sb_q[$];
    int   n_tests;
    int   n_fail;

    pwm_if #(.DUTY_W(8), .CNT_W(8)) bus ();

    pwm #(.PERIOD(P), .DUTY_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of stimulus and record the expected result of that cycle.
    task automatic step(input logic r, input int ot, input logic eo, input int ec);
        exp_t e;
        @(negedge clk);
        rst = r;
        bus.on_time = 8'(ot);
        e.out = eo;
        e.cnt = ec;
        sb_q.push_back(e);
    endtask

    // Run one full period: cnt goes 1..199, then wraps to 0.
    // cur is the duty latched for this period.
    // on_time is ot_a up to and including cnt == chg_at - 1. From the cycle
    // where cnt == chg_at it is ot_b.
    // latched returns the on_time value seen at the wrap.
    task automatic period(input int cur, input int ot_a, input int chg_at,
                          input int ot_b, output int latched);
        int hi;
        int ot;
        int hi2;
        hi = (cur >= P) ? P : cur;
        for (int c = 1; c < P; c++) begin
            ot = (c - 1 >= chg_at) ? ot_b : ot_a;
            step(1'b0, ot, (c < hi), c);
        end
        ot = (P - 1 >= chg_at) ? ot_b : ot_a;
        latched = ot;
        hi2 = (ot >= P) ? P : ot;
        step(1'b0, ot, (0 < hi2), 0);
        $display("[TB] period: duty=%0d high=%0d low=%0d next_duty=%0d",
                 cur, hi, P - hi, latched);
    endtask

    // Monitor: out and cnt are valid every cycle once stimulus has started.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_tests++;
                if (bus.out !== e.out) begin
                    n_fail++;
                    $display("FAIL out: exp_cnt=%0d got=%b want=%b", e.cnt, bus.out, e.out);
                end
                n_tests++;
                if (bus.cnt !== 8'(e.cnt)) begin
                    n_fail++;
                    $display("FAIL cnt: got=%0d want=%0d", bus.cnt, e.cnt);
                end
            end
        end
    end

    initial begin
        int cur;
        int nxt;
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        bus.on_time = 8'd0;

        // Reset: cnt = 0 and out = 0.
        step(1'b1, 0, 1'b0, 0);
        step(1'b1, 0, 1'b0, 0);
        $display("[TB] reset applied");
        cur = 0;

        // Hold on_time at 0 for three periods: out stays low throughout.
        for (int i = 0; i < 3; i++) begin
            period(cur, 0, 1000, 0, nxt);
            cur = nxt;
        end

        // Full scale. There must be no low cycle across the wrap.
        period(cur, 200, 1000, 200, nxt); cur = nxt;
        period(cur, 200, 1000, 200, nxt); cur = nxt;
        period(cur, 255, 1000, 255, nxt); cur = nxt;
        // 255 saturates high, the same as 200.
        period(cur, 255, 1000, 255, nxt); cur = nxt;
        period(cur, 50, 1000, 50, nxt); cur = nxt;
        period(cur, 50, 1000, 50, nxt); cur = nxt;
        // on_time changes 50 -> 120 at cnt 30. This period stays at 50.
        period(cur, 50, 30, 120, nxt); cur = nxt;
        period(cur, 120, 1000, 120, nxt); cur = nxt;
        period(cur, 100, 1000, 100, nxt); cur = nxt;

        // Reset at cnt 10 while running at duty 100.
        for (int c = 1; c <= 10; c++) step(1'b0, 100, (c < cur), c);
        step(1'b1, 100, 1'b0, 0);
        $display("[TB] reset at cnt=10");
        cur = 0;
        // After release: one full period low, then 100/100.
        period(cur, 100, 1000, 100, nxt); cur = nxt;
        period(cur, 100, 1000, 100, nxt); cur = nxt;

        // Drain the scoreboard, with a bounded wait.
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
        #2;
        if (sb_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: got=%0d pending want=0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
